// File: rtl/pulse_blinker.sv
// pulse_blinker: stretches single-cycle event strobes into ON/OFF blinks, queueing events that arrive mid-blink.
module pulse_blinker #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int TW         = 8,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             clr_ovf,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             ovf_q, ovf_d, out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic             tz, restart, queue, drop;

  always_comb begin
    tz        = timer_q == '0;
    restart   = state_q == S_OFF && tz && (pending_q != '0 || in);
    // an event landing on the restart edge is consumed by that restart, never queued
    queue     = in && state_q != S_IDLE && !restart;
    drop      = queue && pending_q == P_MAX;
    state_d   = state_q == S_IDLE ? (in ? S_ON : S_IDLE) :
                !tz               ? state_q :
                state_q == S_ON   ? S_OFF :
                restart           ? S_ON : S_IDLE;
    timer_d   = state_q == S_IDLE ? (in ? ON_LD : '0) :
                !tz               ? timer_q - 1'b1 :
                state_q == S_ON   ? OFF_LD :
                restart           ? ON_LD : '0;
    pending_d = restart && !in    ? pending_q - 1'b1 :
                queue && !drop    ? pending_q + 1'b1 : pending_q;
    ovf_d     = drop | (ovf_q & ~clr_ovf);
    out_d     = state_d == S_ON;
    busy_d    = state_d != S_IDLE;
    done_d    = state_d == S_OFF && timer_d == '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_pulse_blinker.sv
// tb_pulse_blinker: directed checks of blink timing, queueing, overflow, restart and async reset.
module tb_pulse_blinker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_s = 1'b0;
  logic       clr_s = 1'b0;
  logic       out_s, busy_s, done_s, ovf_s;
  logic [1:0] pending_s;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] out_v, done_v, busy_v;
  logic [1:0]  pend_log [0:31];
  logic        ovf_log [0:31];
  int          n_done, n_rise;

  pulse_blinker dut (
    .clk(clk), .reset(reset), .in(in_s), .clr_ovf(clr_s),
    .out(out_s), .busy(busy_s), .done(done_s), .pending(pending_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  // cycle i drives in_v/clr_v bit n-1-i (literals read left to right in time); logs results after each edge
  task automatic run(input int n, input logic [31:0] in_v, input logic [31:0] clr_v);
    logic prev;
    out_v = '0; done_v = '0; busy_v = '0; n_done = 0; n_rise = 0;
    prev = out_s;
    for (int i = 0; i < n; i++) begin
      in_s  = in_v[n-1-i];
      clr_s = clr_v[n-1-i];
      @(posedge clk);
      #1;
      out_v  = {out_v[30:0], out_s};
      done_v = {done_v[30:0], done_s};
      busy_v = {busy_v[30:0], busy_s};
      n_done += int'(done_s);
      n_rise += int'(out_s && !prev);
      prev = out_s;
      pend_log[i] = pending_s;
      ovf_log[i]  = ovf_s;
    end
    in_s = 1'b0;
    clr_s = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_s = 1'b0; clr_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_s !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_s); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_s); end
    checks++; if (pending_s !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending_s); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_s); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    run(8, 32'b10000000, 32'b0);
    checks++; if (out_v[7:0] !== 8'b11110000) begin errors++; $display("FAIL single_out got=%b exp=11110000", out_v[7:0]); end
    checks++; if (done_v[7:0] !== 8'b00000100) begin errors++; $display("FAIL single_done got=%b exp=00000100", done_v[7:0]); end
    checks++; if (busy_v[7:0] !== 8'b11111100) begin errors++; $display("FAIL single_busy got=%b exp=11111100", busy_v[7:0]); end
    checks++; if (pend_log[3] !== 2'd0) begin errors++; $display("FAIL single_pending got=%0d exp=0", pend_log[3]); end
  endtask

  task automatic check_three(input string tag);
    checks++; if (out_v[19:0] !== 20'b11110011110011110000) begin errors++; $display("FAIL %s_out got=%b exp=11110011110011110000", tag, out_v[19:0]); end
    checks++; if (done_v[19:0] !== 20'b00000100000100000100) begin errors++; $display("FAIL %s_done got=%b exp=00000100000100000100", tag, done_v[19:0]); end
    checks++; if (busy_v[19:0] !== 20'hFFFFC) begin errors++; $display("FAIL %s_busy got=%b exp=11111111111111111100", tag, busy_v[19:0]); end
    checks++; if (pend_log[19] !== 2'd0) begin errors++; $display("FAIL %s_pend_end got=%0d exp=0", tag, pend_log[19]); end
  endtask

  task automatic test_queued;
    run(20, 32'b10101 << 15, 32'b0);
    checks++; if (pend_log[2] !== 2'd1) begin errors++; $display("FAIL queued_pend2 got=%0d exp=1", pend_log[2]); end
    checks++; if (pend_log[4] !== 2'd2) begin errors++; $display("FAIL queued_pend4 got=%0d exp=2", pend_log[4]); end
    check_three("queued");
  endtask

  task automatic test_simul_pending;
    run(20, 32'b1010001 << 13, 32'b0);
    checks++; if (pend_log[6] !== 2'd1) begin errors++; $display("FAIL simul1_pend got=%0d exp=1", pend_log[6]); end
    check_three("simul1");
  endtask

  task automatic test_simul_empty;
    run(16, 32'b1000001 << 9, 32'b0);
    checks++; if (pend_log[6] !== 2'd0) begin errors++; $display("FAIL simul0_pend got=%0d exp=0", pend_log[6]); end
    checks++; if (out_v[15:0] !== 16'b1111001111000000) begin errors++; $display("FAIL simul0_out got=%b exp=1111001111000000", out_v[15:0]); end
    checks++; if (done_v[15:0] !== 16'b0000010000010000) begin errors++; $display("FAIL simul0_done got=%b exp=0000010000010000", done_v[15:0]); end
    checks++; if (busy_v[15:0] !== 16'hFFF0) begin errors++; $display("FAIL simul0_busy got=%b exp=1111111111110000", busy_v[15:0]); end
  endtask

  task automatic test_held;
    run(20, 32'b111 << 17, 32'b0);
    checks++; if (pend_log[2] !== 2'd2) begin errors++; $display("FAIL held_pend got=%0d exp=2", pend_log[2]); end
    check_three("held");
  endtask

  task automatic test_overflow;
    run(26, 32'b11111 << 21, 32'b0);
    checks++; if (pend_log[3] !== 2'd3) begin errors++; $display("FAIL ovf_pend_sat got=%0d exp=3", pend_log[3]); end
    checks++; if (pend_log[4] !== 2'd3) begin errors++; $display("FAIL ovf_pend_hold got=%0d exp=3", pend_log[4]); end
    checks++; if (ovf_log[3] !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", ovf_log[3]); end
    checks++; if (ovf_log[4] !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_log[4]); end
    checks++; if (n_rise !== 4) begin errors++; $display("FAIL ovf_blinks got=%0d exp=4", n_rise); end
    checks++; if (n_done !== 4) begin errors++; $display("FAIL ovf_dones got=%0d exp=4", n_done); end
    checks++; if (busy_v[1:0] !== 2'b00) begin errors++; $display("FAIL ovf_idle got=%b exp=00", busy_v[1:0]); end
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_s); end
    run(1, 32'b0, 32'b1);
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_s); end
    run(5, 32'b11111, 32'b00001);
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", ovf_s); end
    run(22, 32'b0, 32'b0);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL ovf_drain got=%b exp=0", busy_v[0]); end
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_after_drain got=%b exp=1", ovf_s); end
  endtask

  task automatic test_async_reset;
    run(4, 32'b1110, 32'b0);
    checks++; if (pending_s !== 2'd2 || out_s !== 1'b1) begin errors++; $display("FAIL areset_pre got pend=%0d out=%b exp pend=2 out=1", pending_s, out_s); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_s !== 1'b0) begin errors++; $display("FAIL areset_out got=%b exp=0", out_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy_s); end
    checks++; if (pending_s !== 2'd0) begin errors++; $display("FAIL areset_pending got=%0d exp=0", pending_s); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL areset_ovf got=%b exp=0", ovf_s); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run(10, 32'b0, 32'b0);
    checks++; if (n_done !== 0 || out_v[9:0] !== 10'b0) begin errors++; $display("FAIL areset_quiet got dones=%0d out=%b exp dones=0 out=0", n_done, out_v[9:0]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_queued;
    test_simul_pending;
    test_simul_empty;
    test_held;
    test_overflow;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
